// File: rtl/cla_add_if.sv
// Operand/result bundle for the two-stage carry-lookahead adder.
interface cla_add_if #(
  parameter int N = 8
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N:0]   sum;

  modport master (output A, B, input sum);
  modport slave  (input A, B, output sum);
endinterface

// File: rtl/cla_add.sv
// Two-stage pipelined unsigned adder: registered operands, two-level
// carry-lookahead (4-bit groups + block-carry unit), registered N+1 bit sum.

// One lookahead group of up to 4 bits: local carries, group generate/propagate.
module cla_blk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         gg,
  output logic         pg
);
  logic [W-1:0] g, p, c;
  logic [W:0]   gen, pall;

  // gen[j]: carry into bit j generated inside the group; pall[j]: bits 0..j-1 all propagate
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    gen  = '0;
    pall = '0;
    c    = '0;
    for (int j = 0; j <= W; j++) begin
      logic t, pa;
      pa = 1'b1;
      for (int m = 0; m < j; m++) pa = pa & p[m];
      pall[j] = pa;
      for (int k = 0; k < j; k++) begin
        t = g[k];
        for (int m = k + 1; m < j; m++) t = t & p[m];
        gen[j] = gen[j] | t;
      end
    end
    for (int j = 0; j < W; j++) c[j] = gen[j] | (pall[j] & cin);
  end

  assign s  = p ^ c;
  assign gg = gen[W];
  assign pg = pall[W];
endmodule

module cla_add #(
  parameter int N = 8
) (
  input  logic     clk,
  input  logic     reset,
  cla_add_if.slave bus
);
  localparam int   NB  = (N + 3) / 4;
  localparam logic CIN = 1'b0;

  logic [N-1:0]  a_q, b_q, s_all;
  logic [NB-1:0] bg, bp;
  logic [NB:0]   bc;

  generate
    for (genvar k = 0; k < NB; k++) begin : g_blk
      localparam int W = (k == NB - 1) ? (N - 4 * k) : 4;
      cla_blk #(.W(W)) u_blk (
        .a   (a_q[4*k +: W]),
        .b   (b_q[4*k +: W]),
        .cin (bc[k]),
        .s   (s_all[4*k +: W]),
        .gg  (bg[k]),
        .pg  (bp[k])
      );
    end
  endgenerate

  // Second-level lookahead: every block carry is a flat sum of products of G/P
  always_comb begin
    bc = '0;
    for (int j = 0; j <= NB; j++) begin
      logic t, cj;
      cj = CIN;
      for (int m = 0; m < j; m++) cj = cj & bp[m];
      for (int k = 0; k < j; k++) begin
        t = bg[k];
        for (int m = k + 1; m < j; m++) t = t & bp[m];
        cj = cj | t;
      end
      bc[j] = cj;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      bus.sum <= '0;
    end else begin
      a_q     <= bus.A;
      b_q     <= bus.B;
      bus.sum <= {bc[NB], s_all};
    end
  end
endmodule

// File: tb/tb_cla_add.sv
// Bench for cla_add at N=8, 6 and 13: directed table, reset sequences, random/exhaustive sweep.
module tb_cla_add;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cla_add_if #(.N(8))  if8 ();
  cla_add_if #(.N(6))  if6 ();
  cla_add_if #(.N(13)) if13 ();

  cla_add #(.N(8))  u8  (.clk(clk), .reset(reset), .bus(if8));
  cla_add #(.N(6))  u6  (.clk(clk), .reset(reset), .bus(if6));
  cla_add #(.N(13)) u13 (.clk(clk), .reset(reset), .bus(if13));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: the sum seen after an edge is the plain sum of the operands
  // presented one edge earlier, or zero if reset was low at either edge.
  logic        seen_rst = 1'b0;
  logic        r_h      = 1'b0;
  logic [63:0] e8_h = '0, e6_h = '0, e13_h = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] a8, input logic [7:0] b8,
                      input logic [5:0] a6, input logic [5:0] b6,
                      input logic [12:0] a13, input logic [12:0] b13);
    reset    = r;
    if8.A    = a8;  if8.B  = b8;
    if6.A    = a6;  if6.B  = b6;
    if13.A   = a13; if13.B = b13;
    @(posedge clk);
    #1;
    if (!r) seen_rst = 1'b1;
    if (seen_rst) begin
      chk("model_n8",  64'(if8.sum),  (r && r_h) ? e8_h  : 64'd0);
      chk("model_n6",  64'(if6.sum),  (r && r_h) ? e6_h  : 64'd0);
      chk("model_n13", 64'(if13.sum), (r && r_h) ? e13_h : 64'd0);
    end
    e8_h  = 64'(a8)  + 64'(b8);
    e6_h  = 64'(a6)  + 64'(b6);
    e13_h = 64'(a13) + 64'(b13);
    r_h   = r;
  endtask

  initial begin
    vec_t tbl[8];
    tbl[0] = '{8'h33, 8'h1E, 9'h051};
    tbl[1] = '{8'h55, 8'h32, 9'h087};
    tbl[2] = '{8'hFF, 8'h01, 9'h100};
    tbl[3] = '{8'hFF, 8'hFF, 9'h1FE};
    tbl[4] = '{8'h0F, 8'h01, 9'h010};
    tbl[5] = '{8'h00, 8'h00, 9'h000};
    tbl[6] = '{8'hF0, 8'h10, 9'h100};
    tbl[7] = '{8'hAA, 8'h55, 9'h0FF};

    // Reset for two edges with zero operands, then release with zeros
    tick(1'b0, 8'h00, 8'h00, 6'd0, 6'd0, 13'd0, 13'd0);
    chk("rst_edge1", 64'(if8.sum), 64'h000);
    tick(1'b0, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 13'h1FFF, 13'h1FFF);
    chk("rst_held", 64'(if8.sum), 64'h000);
    tick(1'b1, 8'h00, 8'h00, 6'd0, 6'd0, 13'd0, 13'd0);
    chk("rel_edge1", 64'(if8.sum), 64'h000);
    tick(1'b1, 8'h00, 8'h00, 6'd0, 6'd0, 13'd0, 13'd0);
    chk("rel_edge2", 64'(if8.sum), 64'h000);

    // Back-to-back directed vectors; result of vector i appears after the next edge
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) tick(1'b1, tbl[i].a, tbl[i].b, 6'd0, 6'd0, 13'd0, 13'd0);
      else       tick(1'b1, 8'h00, 8'h00, 6'd0, 6'd0, 13'd0, 13'd0);
      if (i > 0) chk($sformatf("tbl%0d", i - 1), 64'(if8.sum), 64'(tbl[i-1].exp));
    end

    // Mid-stream reset discards 0x80+0x80 in flight
    tick(1'b1, 8'h80, 8'h80, 6'h20, 6'h20, 13'h1000, 13'h1000);
    tick(1'b1, 8'h80, 8'h80, 6'h20, 6'h20, 13'h1000, 13'h1000);
    chk("pre_rst", 64'(if8.sum), 64'h100);
    tick(1'b0, 8'h80, 8'h80, 6'h20, 6'h20, 13'h1000, 13'h1000);
    chk("mid_rst", 64'(if8.sum), 64'h000);
    tick(1'b1, 8'h01, 8'h02, 6'd1, 6'd2, 13'd1, 13'd2);
    chk("post_rel1", 64'(if8.sum), 64'h000);
    chk("post_rel1_n13", 64'(if13.sum), 64'h0);
    tick(1'b1, 8'h00, 8'h00, 6'd0, 6'd0, 13'd0, 13'd0);
    chk("post_rel2", 64'(if8.sum), 64'h003);
    chk("post_rel2_n6", 64'(if6.sum), 64'h3);

    // N=6 exhaustive, N=13 and N=8 random, all streamed back-to-back
    for (int i = 0; i < 10000; i++) begin
      logic [5:0] a6, b6;
      if (i < 4096) begin
        a6 = 6'(i >> 6);
        b6 = 6'(i);
      end else begin
        a6 = 6'($urandom);
        b6 = 6'($urandom);
      end
      tick(1'b1, 8'($urandom), 8'($urandom), a6, b6, 13'($urandom), 13'($urandom));
    end
    tick(1'b1, 8'h00, 8'h00, 6'd0, 6'd0, 13'd0, 13'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_add.md
CLA_ADD -- requirements
Module: cla_add

Interface
REQ-001 Parameter N, default 8, meaning operand width in bits; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock for all registers.
REQ-003 reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-004 A  input  N  unsigned addend.
REQ-005 B  input  N  unsigned addend.
REQ-006 sum  output  N+1  registered unsigned sum A+B; MSB is carry-out.

Function
REQ-007 The block SHALL compute sum = A + B as an unsigned (N+1)-bit result, never truncated or wrapped.
REQ-008 Carry generation SHALL be carry-lookahead:
  - per-bit generate g[i]=A[i]&B[i] and propagate p[i]=A[i]^B[i]
  - bits grouped in 4-bit blocks, each with group generate G and group propagate P
  - a second-level lookahead unit derives every block carry-in from G/P and carry-in 0
  - no ripple chain between blocks
REQ-009 A final block narrower than 4 bits SHALL be supported when N is not a multiple of 4.
REQ-010 Sum bit i SHALL equal p[i] XOR c[i]; sum[N] SHALL equal the carry out of bit N-1.
REQ-011 The internal carry-in to bit 0 SHALL be constant 0.
REQ-012 Pipeline SHALL be two register stages:
  - input registers capture A and B on each rising clk
  - output register captures the lookahead sum of the input registers on the next rising clk
REQ-013 Latency SHALL be 2 clocks: operands present at rising edge k appear on sum after rising edge k+1.
REQ-014 Throughput SHALL be one new operand pair per clock, with no stall or handshake.
REQ-015 sum SHALL hold its value between edges and SHALL change only on a rising clk edge.
REQ-016 There SHALL be no combinational path from A or B to sum.

Reset
REQ-017 When reset=0 at a rising clk edge, the input registers and the sum register SHALL all load 0.
REQ-018 While reset is held low, sum SHALL remain 0 regardless of A and B.
REQ-019 On the first rising edge with reset=1, the input registers SHALL capture A and B.
  - sum SHALL still show 0 after that edge (the zeros flushed from the input stage)
  - sum SHALL show the first real result after the following edge
REQ-020 Reset asserted mid-stream SHALL discard all in-flight operands; no stale result SHALL appear after release.
REQ-021 Power-up register contents are don't-care until the first reset edge.

Verification
REQ-022 N=8, reset low for 2 edges, A=0x00, B=0x00, then reset high -> sum=0x000 on every edge.
REQ-023 N=8, A=0x33, B=0x1E applied at edge k -> sum=0x051 after edge k+1.
  - next cycle A=0x55, B=0x32 -> sum=0x087 one edge later
  - confirms back-to-back throughput
REQ-024 N=8 carry boundaries:
  - A=0xFF, B=0x01 -> sum=0x100
  - A=0xFF, B=0xFF -> sum=0x1FE
  - A=0x0F, B=0x01 -> sum=0x010 (block-to-block carry)
REQ-025 N=8, stream A=0x80, B=0x80, pull reset low for one edge, then release with A=0x01, B=0x02:
  - sum=0x000 after the reset edge and after the first edge after release
  - sum=0x003 one edge later
  - 0x100 never appears
REQ-026 N=6 and N=13, exhaustive (N=6) or 10,000 random (N=13) operand pairs -> sum equals the (N+1)-bit A+B two clocks later.
